sramlike_fetch_queue: RTL and testbench

//   Parametrised instruction-fetch front end for the sram-like (req/addr_ok/data_ok) bus; successor of the

---
 rtl/sramlike_fetch_queue.sv | 168 ++++++++++++++++
 tb/tb_sramlike_fetch_queue.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sramlike_fetch_queue.sv
// Instruction-fetch front end for an sram-like (req/addr_ok/data_ok) bus: owns the fetch PC,
// keeps up to OUTST requests in flight and buffers returned instructions in an in-order FIFO.
module sramlike_fetch_queue #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       OUTST      = 2,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h1c000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_inst,
  output logic              sram_req,
  output logic              sram_wr,
  output logic [1:0]        sram_size,
  output logic [3:0]        sram_wstrb,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic              sram_addr_ok,
  input  logic              sram_data_ok,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int CNT_W  = $clog2(OUTST + 1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TPTR_W = (OUTST > 1) ? $clog2(OUTST) : 1;

  typedef enum logic [1:0] {IDLE, REQ, REDIR} state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   pc_reg;
  logic [ADDR_W-1:0]   redir_pc_reg;
  logic [CNT_W-1:0]    inflight_reg;
  logic [CNT_W-1:0]    discard_reg;
  logic [TPTR_W-1:0]   tag_wr_ptr_reg;
  logic [TPTR_W-1:0]   tag_rd_ptr_reg;
  logic [PTR_W-1:0]    fifo_wr_ptr_reg;
  logic [PTR_W-1:0]    fifo_rd_ptr_reg;
  logic [FCNT_W-1:0]   fifo_cnt_reg;

  logic [ADDR_W-1:0]   tag_mem   [OUTST];
  logic [ADDR_W-1:0]   fifo_pc   [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_inst [FIFO_DEPTH];

  logic                accept;
  logic                ret;
  logic                push;
  logic                pop;
  logic [CNT_W-1:0]    inflight_next;
  logic [CNT_W-1:0]    discard_next;
  logic [FCNT_W-1:0]   fifo_cnt_next;
  logic [31:0]         inflight_w;
  logic [31:0]         fifo_cnt_w;
  logic                credit_next;

  function automatic logic [PTR_W-1:0] fifo_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [TPTR_W-1:0] tag_inc(input logic [TPTR_W-1:0] p);
    return (p == TPTR_W'(OUTST - 1)) ? '0 : p + TPTR_W'(1);
  endfunction

  assign sram_req   = (state_reg != IDLE);
  assign sram_addr  = pc_reg;
  assign sram_wr    = 1'b0;
  assign sram_size  = 2'd2;
  assign sram_wstrb = 4'd0;
  assign sram_wdata = '0;

  assign out_valid  = (fifo_cnt_reg != '0);
  assign out_pc     = fifo_pc[fifo_rd_ptr_reg];
  assign out_inst   = fifo_inst[fifo_rd_ptr_reg];

  // A return in a flush cycle, or one owed to an older redirect, never reaches the FIFO.
  assign accept = sram_req && sram_addr_ok;
  assign ret    = sram_data_ok && (inflight_reg != '0);
  assign push   = ret && !flush && (discard_reg == '0);
  assign pop    = out_valid && out_ready && !flush;

  assign inflight_next = inflight_reg + CNT_W'(accept) - CNT_W'(ret);
  assign fifo_cnt_next = flush ? '0 : fifo_cnt_reg + FCNT_W'(push) - FCNT_W'(pop);
  assign discard_next  = flush ? inflight_next
                       : discard_reg - CNT_W'(ret && (discard_reg != '0))
                                     + CNT_W'(accept && (state_reg == REDIR));

  // Credit is judged on post-update occupancy so a raised request can always be held safely.
  assign inflight_w  = 32'(inflight_next);
  assign fifo_cnt_w  = 32'(fifo_cnt_next);
  assign credit_next = (inflight_w < OUTST) && ((inflight_w + fifo_cnt_w) < FIFO_DEPTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_PC;
      redir_pc_reg    <= RESET_PC;
      inflight_reg    <= '0;
      discard_reg     <= '0;
      tag_wr_ptr_reg  <= '0;
      tag_rd_ptr_reg  <= '0;
      fifo_wr_ptr_reg <= '0;
      fifo_rd_ptr_reg <= '0;
      fifo_cnt_reg    <= '0;
    end else begin
      inflight_reg <= inflight_next;
      discard_reg  <= discard_next;
      fifo_cnt_reg <= fifo_cnt_next;
      if (accept) tag_wr_ptr_reg <= tag_inc(tag_wr_ptr_reg);
      if (ret)    tag_rd_ptr_reg <= tag_inc(tag_rd_ptr_reg);
      if (flush) begin
        fifo_wr_ptr_reg <= '0;
        fifo_rd_ptr_reg <= '0;
      end else begin
        if (push) fifo_wr_ptr_reg <= fifo_inc(fifo_wr_ptr_reg);
        if (pop)  fifo_rd_ptr_reg <= fifo_inc(fifo_rd_ptr_reg);
      end
      case (state_reg)
        IDLE: begin
          if (flush)            pc_reg <= flush_pc;
          else if (credit_next) state_reg <= REQ;
        end
        REQ: begin
          if (accept) begin
            if (flush) begin
              pc_reg    <= flush_pc;
              state_reg <= IDLE;
            end else begin
              pc_reg    <= pc_reg + ADDR_W'(4);
              state_reg <= credit_next ? REQ : IDLE;
            end
          end else if (flush) begin
            redir_pc_reg <= flush_pc;
            state_reg    <= REDIR;
          end
        end
        REDIR: begin
          // The held request still goes to the old address; only its completion moves the PC.
          if (accept) begin
            pc_reg    <= flush ? flush_pc : redir_pc_reg;
            state_reg <= IDLE;
          end else if (flush) begin
            redir_pc_reg <= flush_pc;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) tag_mem[tag_wr_ptr_reg] <= pc_reg;
    if (push) begin
      fifo_pc[fifo_wr_ptr_reg]   <= tag_mem[tag_rd_ptr_reg];
      fifo_inst[fifo_wr_ptr_reg] <= sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && sram_data_ok) assert (inflight_reg != '0);
  end

endmodule

// File: tb/tb_sramlike_fetch_queue.sv
// Directed phases plus randomized bus traffic, checked every cycle against a queue-based fetch model.
module tb_sramlike_fetch_queue;

  localparam int          ADDR_W     = 32;
  localparam int          DATA_W     = 32;
  localparam int          OUTST      = 2;
  localparam int          FIFO_DEPTH = 4;
  localparam logic [31:0] RESET_PC   = 32'h1c000000;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [DATA_W-1:0] out_inst;
  logic              sram_req;
  logic              sram_wr;
  logic [1:0]        sram_size;
  logic [3:0]        sram_wstrb;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic              sram_addr_ok;
  logic              sram_data_ok;
  logic [DATA_W-1:0] sram_rdata;

  always #5 clk = ~clk;

  sramlike_fetch_queue #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUTST(OUTST), .FIFO_DEPTH(FIFO_DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .flush_pc(flush_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size), .sram_wstrb(sram_wstrb),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_addr_ok(sram_addr_ok),
    .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata)
  );

  typedef struct {logic [31:0] addr; bit discard; int acc_cyc;} tag_t;
  typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;

  // Reference model: accepted requests in bus order, and the instruction buffer contents.
  tag_t        tag_q[$];
  ent_t        fifo_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_redir;
  bit          m_pending;
  bit          exp_req;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  int          p_aok, p_dok, p_rdy, p_fl, lat_min;
  bit          f_fl, f_aok, f_dok, fixed_rdata;
  logic [31:0] f_pc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(7) == 0) return {28'hfffffff, r[3:2], 2'b00};
    return {r[31:2], 2'b00};
  endfunction

  task automatic model_reset();
    tag_q.delete();
    fifo_q.delete();
    m_pc      = RESET_PC;
    m_redir   = RESET_PC;
    m_pending = 1'b0;
    exp_req   = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset        = 1'b1;
    flush        = 1'b0;
    sram_addr_ok = 1'b0;
    sram_data_ok = 1'b0;
    out_ready    = 1'b0;
    repeat (n) @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge: check outputs, drive this cycle's inputs, advance the model, step one clock.
  task automatic cycle();
    tag_t t;
    bit   acc, dok, fl, rdy, was_pend, credit;
    check("out_valid", 64'(out_valid), 64'(fifo_q.size() != 0));
    if (fifo_q.size() != 0) begin
      check("out_pc", 64'(out_pc), 64'(fifo_q[0].pc));
      check("out_inst", 64'(out_inst), 64'(fifo_q[0].inst));
    end
    check("sram_req", 64'(sram_req), 64'(exp_req));
    if (exp_req) check("sram_addr", 64'(sram_addr), 64'(m_pc));

    fl  = f_fl || ($urandom_range(99) < p_fl);
    acc = exp_req && (f_aok || ($urandom_range(99) < p_aok));
    dok = (tag_q.size() != 0) && ((cyc - tag_q[0].acc_cyc) >= lat_min)
          && (f_dok || ($urandom_range(99) < p_dok));
    rdy = ($urandom_range(99) < p_rdy);
    flush        = fl;
    flush_pc     = f_fl ? f_pc : rand_pc();
    sram_addr_ok = acc;
    sram_data_ok = dok;
    sram_rdata   = fixed_rdata ? 32'h02800000 : $urandom;
    out_ready    = rdy;

    was_pend = m_pending;
    if (!fl && rdy && fifo_q.size() != 0) fifo_q.delete(0);
    if (dok) begin
      t = tag_q.pop_front();
      if (!(t.discard || fl)) fifo_q.push_back('{pc: t.addr, inst: sram_rdata});
    end
    if (acc) begin
      tag_q.push_back('{addr: m_pc, discard: (fl || m_pending), acc_cyc: cyc});
      if (fl)             m_pc = flush_pc;
      else if (m_pending) m_pc = m_redir;
      else                m_pc = m_pc + 32'd4;
      m_pending = 1'b0;
    end else if (fl) begin
      if (exp_req) begin
        m_pending = 1'b1;
        m_redir   = flush_pc;
      end else begin
        m_pc = flush_pc;
      end
    end
    if (fl) begin
      foreach (tag_q[i]) tag_q[i].discard = 1'b1;
      fifo_q.delete();
    end
    credit  = (tag_q.size() < OUTST) && ((tag_q.size() + fifo_q.size()) < FIFO_DEPTH);
    exp_req = (exp_req && !acc) || (credit && !fl && !(acc && was_pend));
    f_fl  = 1'b0;
    f_aok = 1'b0;
    f_dok = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic knobs(input int aok, input int dk, input int rd, input int fl, input int lat);
    p_aok   = aok;
    p_dok   = dk;
    p_rdy   = rd;
    p_fl    = fl;
    lat_min = lat;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; flush_pc = '0; out_ready = 1'b0;
    sram_addr_ok = 1'b0; sram_data_ok = 1'b0; sram_rdata = '0;
    f_fl = 1'b0; f_aok = 1'b0; f_dok = 1'b0; f_pc = '0; fixed_rdata = 1'b1;
    knobs(100, 100, 100, 0, 1);
    model_reset();
    @(negedge clk);
    do_reset(3);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_sram_req", 64'(sram_req), 64'd0);
    check("sram_wr", 64'(sram_wr), 64'd0);
    check("sram_size", 64'(sram_size), 64'd2);
    check("sram_wstrb", 64'(sram_wstrb), 64'd0);
    check("sram_wdata", 64'(sram_wdata), 64'd0);

    // Fast bus: accept immediately, return next cycle.
    repeat (12) cycle();
    fixed_rdata = 1'b0;

    // Slow returns: at most OUTST in flight, output strictly in PC order.
    knobs(100, 100, 100, 0, 3);
    repeat (20) cycle();

    // Consumer stalled: buffer fills to FIFO_DEPTH, then drains in order.
    knobs(100, 100, 0, 0, 1);
    repeat (12) cycle();
    knobs(100, 100, 100, 0, 1);
    repeat (12) cycle();

    // Redirect with both requests in flight.
    knobs(100, 0, 100, 0, 1);
    repeat (6) cycle();
    f_fl = 1'b1; f_pc = 32'h1c000100;
    cycle();
    knobs(100, 100, 100, 0, 1);
    repeat (12) cycle();

    // Redirect while a request is held waiting for addr_ok.
    knobs(0, 100, 100, 0, 1);
    for (int i = 0; i < 10 && !sram_req; i++) cycle();
    check("t5_req_up", 64'(sram_req), 64'd1);
    f_fl = 1'b1; f_pc = 32'h1c000200;
    cycle();
    repeat (3) cycle();
    knobs(100, 100, 100, 0, 1);
    repeat (10) cycle();

    // Flush, accept and return in one cycle, then reset in the middle of a burst.
    for (int i = 0; i < 10 && !(sram_req && tag_q.size() != 0); i++) cycle();
    check("t6_req_up", 64'(sram_req), 64'd1);
    f_fl = 1'b1; f_aok = 1'b1; f_dok = 1'b1; f_pc = 32'h1c000300;
    cycle();
    repeat (3) cycle();
    do_reset(2);
    repeat (10) cycle();

    // PC wrap at the top of the address space.
    f_fl = 1'b1; f_pc = 32'hfffffff8;
    cycle();
    repeat (10) cycle();

    // Randomized traffic with occasional redirects and resets.
    for (int seg = 0; seg < 40; seg++) begin
      knobs($urandom_range(100, 20), $urandom_range(100, 20), $urandom_range(100, 0),
            $urandom_range(5, 0), $urandom_range(4, 1));
      if (seg % 10 == 9) do_reset(1);
      repeat (100) cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (passed %0d of %0d)", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
